// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). One request outstanding at a time.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests and loads the IF/ID register, inserting NOP bubbles when empty.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall_d,
  input  logic                 flush_d,
  input  logic                 pc_src_e,
  input  logic [31:0]          pc_target_e,
  output logic [31:0]          instr_d,
  output logic [31:0]          pc_d,
  output logic [31:0]          pc_plus4_d,
  output logic                 valid_d
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, STALLED} state_t;

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_req_addr;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;

  state_t      w_state_n;
  logic [31:0] w_pc_f_n;
  logic [31:0] w_req_addr_n;
  logic [31:0] w_next_pc;
  logic [31:0] w_req_plus4;
  logic        w_skid_ld;
  logic        w_avail;
  logic [31:0] w_avail_instr;
  logic [31:0] w_avail_pc;

  assign imem.imem_req  = (r_state == FETCH);
  assign imem.imem_addr = r_req_addr;

  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

  always_comb begin
    w_state_n     = r_state;
    w_pc_f_n      = r_pc_f;
    w_req_addr_n  = r_req_addr;
    w_skid_ld     = 1'b0;
    w_avail       = 1'b0;
    w_avail_instr = r_skid_instr;
    w_avail_pc    = r_skid_pc;
    w_next_pc     = pc_src_e ? pc_target_e : r_pc_f;
    w_req_plus4   = r_req_addr + 32'd4;

    case (r_state)
      BOOT: begin
        w_state_n    = FETCH;
        w_pc_f_n     = w_next_pc;
        w_req_addr_n = w_next_pc;
      end
      FETCH: begin
        if (pc_src_e) begin
          w_pc_f_n = pc_target_e;
          if (imem.imem_rvalid) w_req_addr_n = pc_target_e;
          else                  w_state_n    = DRAIN;
        end else if (imem.imem_rvalid) begin
          w_pc_f_n = w_req_plus4;
          if (stall_d) begin
            w_skid_ld = 1'b1;
            w_state_n = STALLED;
          end else begin
            w_avail       = 1'b1;
            w_avail_instr = imem.imem_rdata;
            w_avail_pc    = r_req_addr;
            w_req_addr_n  = w_req_plus4;
          end
        end
      end
      STALLED: begin
        if (pc_src_e) begin
          w_pc_f_n     = pc_target_e;
          w_req_addr_n = pc_target_e;
          w_state_n    = FETCH;
        end else if (!stall_d) begin
          w_avail      = 1'b1;
          w_req_addr_n = r_pc_f;
          w_state_n    = FETCH;
        end
      end
      DRAIN: begin
        // A redirect coinciding with the stale response still ends the drain,
        // otherwise no further response would ever arrive.
        w_pc_f_n = w_next_pc;
        if (imem.imem_rvalid) begin
          w_req_addr_n = w_next_pc;
          w_state_n    = FETCH;
        end
      end
      default: w_state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc_f       <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_skid_instr <= NOP;
      r_skid_pc    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc_f     <= w_pc_f_n;
      r_req_addr <= w_req_addr_n;
      if (w_skid_ld) begin
        r_skid_instr <= imem.imem_rdata;
        r_skid_pc    <= r_req_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d    <= NOP;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (flush_d) begin
      r_instr_d    <= NOP;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (stall_d) begin
      r_instr_d    <= r_instr_d;
    end else if (w_avail) begin
      r_instr_d    <= w_avail_instr;
      r_pc_d       <= w_avail_pc;
      r_pc_plus4_d <= w_avail_pc + 32'd4;
      r_valid_d    <= 1'b1;
    end else begin
      r_instr_d    <= NOP;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end
  end

endmodule
